// File: rtl/sc_reglane_bank_if.sv
// ---------------------------------------------------------------------------
// sc_reglane_bank_if
//
// Purpose: bundles the load/run controls and the lane output buses of
// sc_reglane_bank so the game-control FSM (master) and the lane bank (slave)
// can be wired with a single connection. Clock and reset are not part of the
// bundle; they stay plain ports on the bank.
//
// Signals:
//   SC_RegLANEBANK_load_InLow     active-low load strobe for the selected lane
//   SC_RegLANEBANK_lanesel_InBUS  lane index targeted by a load (SELWIDTH)
//   SC_RegLANEBANK_data_InBUS     pattern to load (DATAWIDTH)
//   SC_RegLANEBANK_period_InBUS   shift period to load, 0 = never shift
//   SC_RegLANEBANK_dir_InBUS      01 rotate left, 10 rotate right, else hold
//   SC_RegLANEBANK_enable_In      global run/pause for every lane
//   SC_RegLANEBANK_fill_InBUS     per-lane shift-in bit (only with
//                                 SC_REGLANEBANK_FILL_EN defined)
//   SC_RegLANEBANK_data_OutBUS    lane i at [i*DATAWIDTH +: DATAWIDTH]
//   SC_RegLANEBANK_tick_OutBUS    bit i high for one cycle when lane i shifts
// ---------------------------------------------------------------------------
interface sc_reglane_bank_if #(
  parameter int DATAWIDTH = 8,
  parameter int LANES     = 4,
  parameter int SELWIDTH  = 2,
  parameter int DIVWIDTH  = 8
);

  logic                          SC_RegLANEBANK_load_InLow;
  logic [SELWIDTH-1:0]           SC_RegLANEBANK_lanesel_InBUS;
  logic [DATAWIDTH-1:0]          SC_RegLANEBANK_data_InBUS;
  logic [DIVWIDTH-1:0]           SC_RegLANEBANK_period_InBUS;
  logic [1:0]                    SC_RegLANEBANK_dir_InBUS;
  logic                          SC_RegLANEBANK_enable_In;
`ifdef SC_REGLANEBANK_FILL_EN
  logic [LANES-1:0]              SC_RegLANEBANK_fill_InBUS;
`endif
  logic [LANES*DATAWIDTH-1:0]    SC_RegLANEBANK_data_OutBUS;
  logic [LANES-1:0]              SC_RegLANEBANK_tick_OutBUS;

  // Game-control side: drives the load/run controls, reads the lane buses.
  modport master (
    output SC_RegLANEBANK_load_InLow,
    output SC_RegLANEBANK_lanesel_InBUS,
    output SC_RegLANEBANK_data_InBUS,
    output SC_RegLANEBANK_period_InBUS,
    output SC_RegLANEBANK_dir_InBUS,
    output SC_RegLANEBANK_enable_In,
`ifdef SC_REGLANEBANK_FILL_EN
    output SC_RegLANEBANK_fill_InBUS,
`endif
    input  SC_RegLANEBANK_data_OutBUS,
    input  SC_RegLANEBANK_tick_OutBUS
  );

  // Lane-bank side.
  modport slave (
    input  SC_RegLANEBANK_load_InLow,
    input  SC_RegLANEBANK_lanesel_InBUS,
    input  SC_RegLANEBANK_data_InBUS,
    input  SC_RegLANEBANK_period_InBUS,
    input  SC_RegLANEBANK_dir_InBUS,
    input  SC_RegLANEBANK_enable_In,
`ifdef SC_REGLANEBANK_FILL_EN
    input  SC_RegLANEBANK_fill_InBUS,
`endif
    output SC_RegLANEBANK_data_OutBUS,
    output SC_RegLANEBANK_tick_OutBUS
  );

endinterface

// File: rtl/sc_reglane_bank.sv
// ---------------------------------------------------------------------------
// sc_reglane_bank
//
// Purpose: LANES independent background-pattern registers, DATAWIDTH bits
// each. Every lane shifts at its own programmable period and direction, so a
// single block drives all scrolling rows of the playfield. The game-control
// FSM loads pattern/period/direction per lane; the display driver reads the
// flat data bus; collision logic follows the per-lane tick pulses.
//
// Ports:
//   SC_RegLANEBANK_CLOCK_50      system clock, rising-edge active
//   SC_RegLANEBANK_RESET_InHigh  synchronous active-high reset
//   laneBus                      sc_reglane_bank_if.slave (controls + outputs)
//
// Optional feature (compile-time macro SC_REGLANEBANK_FILL_EN):
//   defined   - shifts take their incoming bit from fill_InBUS[i] instead of
//               rotating, so traffic can enter and leave a lane;
//   undefined - pure rotation, no fill port.
//
// Parameters: DATAWIDTH (>=2), LANES (>=1), SELWIDTH (2**SELWIDTH >= LANES),
// DIVWIDTH (period/counter width).
// ---------------------------------------------------------------------------
module sc_reglane_bank #(
  parameter int DATAWIDTH = 8,
  parameter int LANES     = 4,
  parameter int SELWIDTH  = 2,
  parameter int DIVWIDTH  = 8
) (
  input logic             SC_RegLANEBANK_CLOCK_50,
  input logic             SC_RegLANEBANK_RESET_InHigh,
  sc_reglane_bank_if.slave laneBus
);

  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  // Shift helpers: the caller chooses the incoming bit, which is the bit
  // falling off the other end for rotation or the fill bit otherwise.
  function automatic logic [DATAWIDTH-1:0] shiftLeft(
    input logic [DATAWIDTH-1:0] pat,
    input logic                 inBit
  );
    return {pat[DATAWIDTH-2:0], inBit};
  endfunction

  function automatic logic [DATAWIDTH-1:0] shiftRight(
    input logic [DATAWIDTH-1:0] pat,
    input logic                 inBit
  );
    return {inBit, pat[DATAWIDTH-1:1]};
  endfunction

  // Registered per-lane state.
  logic [DATAWIDTH-1:0] pattern_p0 [LANES];
  logic [DIVWIDTH-1:0]  period_p0  [LANES];
  logic [1:0]           dir_p0     [LANES];
  logic [DIVWIDTH-1:0]  counter_p0 [LANES];
  logic [LANES-1:0]     tick_p0;

  // Next-state values.
  logic [DATAWIDTH-1:0] patternNext [LANES];
  logic [DIVWIDTH-1:0]  periodNext  [LANES];
  logic [1:0]           dirNext     [LANES];
  logic [DIVWIDTH-1:0]  counterNext [LANES];
  logic [LANES-1:0]     tickNext;

  always_comb begin
    tickNext = '0;
    for (int i = 0; i < LANES; i++) begin
      patternNext[i] = pattern_p0[i];
      periodNext[i]  = period_p0[i];
      dirNext[i]     = dir_p0[i];
      counterNext[i] = counter_p0[i];
    end

    for (int i = 0; i < LANES; i++) begin
      logic loadHit;
      logic active;
      logic leftIn;
      logic rightIn;

      // An out-of-range lanesel never equals any lane index, so such a load
      // is dropped without a separate range check.
      loadHit = !laneBus.SC_RegLANEBANK_load_InLow &&
                (int'(laneBus.SC_RegLANEBANK_lanesel_InBUS) == i);

      active  = laneBus.SC_RegLANEBANK_enable_In &&
                ((dir_p0[i] == DIR_LEFT) || (dir_p0[i] == DIR_RIGHT)) &&
                (period_p0[i] != '0);

`ifdef SC_REGLANEBANK_FILL_EN
      leftIn  = laneBus.SC_RegLANEBANK_fill_InBUS[i];
      rightIn = laneBus.SC_RegLANEBANK_fill_InBUS[i];
`else
      leftIn  = pattern_p0[i][DATAWIDTH-1];
      rightIn = pattern_p0[i][0];
`endif

      if (loadHit) begin
        // A load restarts the lane's cadence; it never shifts on this edge.
        patternNext[i] = laneBus.SC_RegLANEBANK_data_InBUS;
        periodNext[i]  = laneBus.SC_RegLANEBANK_period_InBUS;
        dirNext[i]     = laneBus.SC_RegLANEBANK_dir_InBUS;
        counterNext[i] = '0;
      end else if (active) begin
        // Counter runs 0..period inclusive, giving one shift per period+1
        // edges; period = all-ones therefore never needs a wrap past it.
        if (counter_p0[i] == period_p0[i]) begin
          counterNext[i] = '0;
          tickNext[i]    = 1'b1;
          if (dir_p0[i] == DIR_LEFT) begin
            patternNext[i] = shiftLeft(pattern_p0[i], leftIn);
          end else begin
            patternNext[i] = shiftRight(pattern_p0[i], rightIn);
          end
        end else begin
          counterNext[i] = counter_p0[i] + DIVWIDTH'(1);
        end
      end
    end
  end

  // Stage p0: lane state and tick register.
  always_ff @(posedge SC_RegLANEBANK_CLOCK_50) begin
    if (SC_RegLANEBANK_RESET_InHigh) begin
      tick_p0 <= '0;
      for (int i = 0; i < LANES; i++) begin
        pattern_p0[i] <= '0;
        period_p0[i]  <= '0;
        dir_p0[i]     <= '0;
        counter_p0[i] <= '0;
      end
    end else begin
      tick_p0 <= tickNext;
      for (int i = 0; i < LANES; i++) begin
        pattern_p0[i] <= patternNext[i];
        period_p0[i]  <= periodNext[i];
        dir_p0[i]     <= dirNext[i];
        counter_p0[i] <= counterNext[i];
      end
    end
  end

  // Flatten the lane patterns onto the display bus, lane 0 in the LSBs.
  for (genvar g = 0; g < LANES; g++) begin : g_laneOut
    assign laneBus.SC_RegLANEBANK_data_OutBUS[g*DATAWIDTH +: DATAWIDTH] = pattern_p0[g];
  end

  assign laneBus.SC_RegLANEBANK_tick_OutBUS = tick_p0;

endmodule

// File: tb/tb_sc_reglane_bank.sv
// ---------------------------------------------------------------------------
// tb_sc_reglane_bank
//
// Directed bench for sc_reglane_bank: a table of per-cycle vectors with
// hand-computed expected buses, followed by hand-written sequences for reset,
// pause/resume, never-shifting lanes, maximum period, out-of-range lanesel
// (on a LANES=3 instance) and the fill/rotation behaviour.
// ---------------------------------------------------------------------------
module tb_sc_reglane_bank;

  logic SC_RegLANEBANK_CLOCK_50 = 1'b0;
  logic SC_RegLANEBANK_RESET_InHigh;

  always #5 SC_RegLANEBANK_CLOCK_50 = ~SC_RegLANEBANK_CLOCK_50;

  sc_reglane_bank_if #(.DATAWIDTH(8), .LANES(4), .SELWIDTH(2), .DIVWIDTH(8)) bus4 ();
  sc_reglane_bank_if #(.DATAWIDTH(8), .LANES(3), .SELWIDTH(2), .DIVWIDTH(8)) bus3 ();

  sc_reglane_bank #(.DATAWIDTH(8), .LANES(4), .SELWIDTH(2), .DIVWIDTH(8)) dut (
    .SC_RegLANEBANK_CLOCK_50     (SC_RegLANEBANK_CLOCK_50),
    .SC_RegLANEBANK_RESET_InHigh (SC_RegLANEBANK_RESET_InHigh),
    .laneBus                     (bus4)
  );

  sc_reglane_bank #(.DATAWIDTH(8), .LANES(3), .SELWIDTH(2), .DIVWIDTH(8)) dut3 (
    .SC_RegLANEBANK_CLOCK_50     (SC_RegLANEBANK_CLOCK_50),
    .SC_RegLANEBANK_RESET_InHigh (SC_RegLANEBANK_RESET_InHigh),
    .laneBus                     (bus3)
  );

  typedef struct {
    logic        loadN;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [7:0]  period;
    logic [1:0]  dir;
    logic        en;
    logic [31:0] expData;
    logic [3:0]  expTick;
  } vec_t;

  vec_t tbl [20];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic loadN, input logic [1:0] sel, input logic [7:0] data,
                        input logic [7:0] period, input logic [1:0] dir, input logic en);
    bus4.SC_RegLANEBANK_load_InLow    = loadN;
    bus4.SC_RegLANEBANK_lanesel_InBUS = sel;
    bus4.SC_RegLANEBANK_data_InBUS    = data;
    bus4.SC_RegLANEBANK_period_InBUS  = period;
    bus4.SC_RegLANEBANK_dir_InBUS     = dir;
    bus4.SC_RegLANEBANK_enable_In     = en;
  endtask

  task automatic drive3(input logic loadN, input logic [1:0] sel, input logic [7:0] data,
                        input logic [7:0] period, input logic [1:0] dir, input logic en);
    bus3.SC_RegLANEBANK_load_InLow    = loadN;
    bus3.SC_RegLANEBANK_lanesel_InBUS = sel;
    bus3.SC_RegLANEBANK_data_InBUS    = data;
    bus3.SC_RegLANEBANK_period_InBUS  = period;
    bus3.SC_RegLANEBANK_dir_InBUS     = dir;
    bus3.SC_RegLANEBANK_enable_In     = en;
  endtask

  // One rising edge, then settle just after it before sampling.
  task automatic cyc();
    @(posedge SC_RegLANEBANK_CLOCK_50);
    #1;
  endtask

  initial begin
    int bad;

    // Lane3 held (dir 00), lane1 held (dir 11), lane0 rotating left every
    // 3 edges, lane2 rotating right every 2 edges.
    tbl[0]  = '{1'b0, 2'd3, 8'hA5, 8'd3, 2'b00, 1'b1, 32'hA500_0000, 4'h0};
    tbl[1]  = '{1'b0, 2'd1, 8'h5A, 8'd1, 2'b11, 1'b1, 32'hA500_5A00, 4'h0};
    tbl[2]  = '{1'b0, 2'd0, 8'h81, 8'd2, 2'b01, 1'b1, 32'hA500_5A81, 4'h0};
    tbl[3]  = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA500_5A81, 4'h0};
    tbl[4]  = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA500_5A81, 4'h0};
    tbl[5]  = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA500_5A03, 4'h1};
    tbl[6]  = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA500_5A03, 4'h0};
    tbl[7]  = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA500_5A03, 4'h0};
    tbl[8]  = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA500_5A06, 4'h1};
    tbl[9]  = '{1'b0, 2'd2, 8'hF0, 8'd1, 2'b10, 1'b1, 32'hA5F0_5A06, 4'h0};
    tbl[10] = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA5F0_5A06, 4'h0};
    tbl[11] = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA578_5A0C, 4'h5};
    tbl[12] = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA578_5A0C, 4'h0};
    tbl[13] = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA53C_5A0C, 4'h4};
    tbl[14] = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA53C_5A18, 4'h1};
    tbl[15] = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA51E_5A18, 4'h4};
    tbl[16] = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA51E_5A18, 4'h0};
    tbl[17] = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA50F_5A30, 4'h5};
    tbl[18] = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA50F_5A30, 4'h0};
    tbl[19] = '{1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1, 32'hA587_5A30, 4'h4};

`ifdef SC_REGLANEBANK_FILL_EN
    bus4.SC_RegLANEBANK_fill_InBUS = '0;
    bus3.SC_RegLANEBANK_fill_InBUS = '0;
`endif

    // Reset with a load requested on the same edge: the load must be lost.
    SC_RegLANEBANK_RESET_InHigh = 1'b1;
    drive4(1'b0, 2'd0, 8'hFF, 8'd1, 2'b01, 1'b1);
    drive3(1'b0, 2'd0, 8'hFF, 8'd1, 2'b01, 1'b1);
    cyc();
    check("reset_data", bus4.SC_RegLANEBANK_data_OutBUS, 32'h0);
    check("reset_tick", {28'h0, bus4.SC_RegLANEBANK_tick_OutBUS}, 32'h0);
    check("reset_data3", {8'h0, bus3.SC_RegLANEBANK_data_OutBUS}, 32'h0);
    SC_RegLANEBANK_RESET_InHigh = 1'b0;
    drive3(1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b0);

    // Table-driven run.
    for (int v = 0; v < 20; v++) begin
      drive4(tbl[v].loadN, tbl[v].sel, tbl[v].data, tbl[v].period, tbl[v].dir, tbl[v].en);
      cyc();
      check($sformatf("vec%0d_data", v), bus4.SC_RegLANEBANK_data_OutBUS, tbl[v].expData);
      check($sformatf("vec%0d_tick", v), {28'h0, bus4.SC_RegLANEBANK_tick_OutBUS},
            {28'h0, tbl[v].expTick});
    end

    // Reset in the middle of running lanes, again overriding a load.
    SC_RegLANEBANK_RESET_InHigh = 1'b1;
    drive4(1'b0, 2'd2, 8'hFF, 8'd1, 2'b01, 1'b1);
    cyc();
    check("midreset_data", bus4.SC_RegLANEBANK_data_OutBUS, 32'h0);
    check("midreset_tick", {28'h0, bus4.SC_RegLANEBANK_tick_OutBUS}, 32'h0);
    SC_RegLANEBANK_RESET_InHigh = 1'b0;
    drive4(1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1);
    cyc(); cyc(); cyc();
    check("postreset_idle", bus4.SC_RegLANEBANK_data_OutBUS, 32'h0);

    // Pause/resume: load while disabled, count to 2, pause 10 edges, resume.
    drive4(1'b0, 2'd0, 8'h01, 8'd4, 2'b01, 1'b0);
    cyc();
    check("pause_load_disabled", bus4.SC_RegLANEBANK_data_OutBUS, 32'h0000_0001);
    drive4(1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1);
    cyc(); cyc();
    check("pause_before", bus4.SC_RegLANEBANK_data_OutBUS, 32'h0000_0001);
    bus4.SC_RegLANEBANK_enable_In = 1'b0;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (bus4.SC_RegLANEBANK_data_OutBUS !== 32'h1 || bus4.SC_RegLANEBANK_tick_OutBUS !== 4'h0)
        bad++;
    end
    check("pause_frozen_cycles_bad", bad, 0);
    bus4.SC_RegLANEBANK_enable_In = 1'b1;
    cyc();
    check("resume_edge1", {bus4.SC_RegLANEBANK_tick_OutBUS, bus4.SC_RegLANEBANK_data_OutBUS[27:0]},
          32'h0000_0001);
    cyc();
    check("resume_edge2", {bus4.SC_RegLANEBANK_tick_OutBUS, bus4.SC_RegLANEBANK_data_OutBUS[27:0]},
          32'h0000_0001);
    cyc();
    check("resume_edge3", {bus4.SC_RegLANEBANK_tick_OutBUS, bus4.SC_RegLANEBANK_data_OutBUS[27:0]},
          32'h1000_0002);
    // Hold lane0 so the next sequence sees a still lane0.
    drive4(1'b0, 2'd0, 8'h02, 8'd0, 2'b00, 1'b1);
    cyc();

    // Period 0 (lane1), dir 11 (lane2) and maximum period 255 (lane3).
    drive4(1'b0, 2'd1, 8'h81, 8'd0, 2'b01, 1'b1);
    cyc();
    drive4(1'b0, 2'd2, 8'h81, 8'd5, 2'b11, 1'b1);
    cyc();
    drive4(1'b0, 2'd3, 8'h01, 8'd255, 2'b01, 1'b1);
    cyc();
    drive4(1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1);
    bad = 0;
    for (int n = 1; n <= 300; n++) begin
      cyc();
      if (bus4.SC_RegLANEBANK_data_OutBUS[23:0] !== 24'h81_81_02 ||
          bus4.SC_RegLANEBANK_tick_OutBUS[2:0] !== 3'b000)
        bad++;
      if (n == 255)
        check("maxperiod_before", {bus4.SC_RegLANEBANK_tick_OutBUS[3], 23'h0,
              bus4.SC_RegLANEBANK_data_OutBUS[31:24]}, 32'h0000_0001);
      if (n == 256)
        check("maxperiod_shift", {bus4.SC_RegLANEBANK_tick_OutBUS[3], 23'h0,
              bus4.SC_RegLANEBANK_data_OutBUS[31:24]}, 32'h8000_0002);
      if (n == 257)
        check("maxperiod_after", {bus4.SC_RegLANEBANK_tick_OutBUS[3], 23'h0,
              bus4.SC_RegLANEBANK_data_OutBUS[31:24]}, 32'h0000_0002);
    end
    check("noshift_lanes_bad_cycles", bad, 0);

    // LANES=3 instance: lanesel=3 must be ignored.
    drive3(1'b0, 2'd0, 8'h3C, 8'd1, 2'b00, 1'b1);
    cyc();
    check("l3_load_lane0", {8'h0, bus3.SC_RegLANEBANK_data_OutBUS}, 32'h0000_003C);
    drive3(1'b0, 2'd3, 8'hFF, 8'd1, 2'b01, 1'b1);
    cyc();
    check("l3_sel3_ignored", {8'h0, bus3.SC_RegLANEBANK_data_OutBUS}, 32'h0000_003C);
    drive3(1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1);
    cyc(); cyc(); cyc();
    check("l3_sel3_later", {5'h0, bus3.SC_RegLANEBANK_tick_OutBUS, bus3.SC_RegLANEBANK_data_OutBUS},
          32'h0000_003C);

    // Lane1 = 01, left, period 1: eight shifts take 16 edges.
    drive4(1'b0, 2'd1, 8'h01, 8'd1, 2'b01, 1'b1);
    cyc();
    drive4(1'b1, 2'd0, 8'h00, 8'd0, 2'b00, 1'b1);
    cyc(); cyc();
    check("lane1_first_shift", {24'h0, bus4.SC_RegLANEBANK_data_OutBUS[15:8]}, 32'h02);
    for (int n = 0; n < 14; n++) cyc();
`ifdef SC_REGLANEBANK_FILL_EN
    check("lane1_after8_fill", {24'h0, bus4.SC_RegLANEBANK_data_OutBUS[15:8]}, 32'h00);
`else
    check("lane1_after8_rotate", {24'h0, bus4.SC_RegLANEBANK_data_OutBUS[15:8]}, 32'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
